execute_cycle: RTL

Execute stage of the 5-stage RISC-V pipeline, between the decode stage (ID/EX register) and `datamem_cycle`. Resolves operand forwarding, performs the ALU operation, computes the branch target and taken decision, and registers the results into the EX/MEM pipeline register. The registered outputs feed `datamem_cycle` directly.

---
 rtl/execute_cycle.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/execute_cycle.sv
// execute_cycle
//   Execute stage of the 5-stage RISC-V pipeline. Resolves operand forwarding,
//   runs the ALU, computes the branch target and taken decision, and registers
//   the results into the EX/MEM pipeline register feeding datamem_cycle.
//
// Ports
//   clk                 pipeline clock, rising edge
//   rst                 asynchronous, active-low reset
//   RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE
//                       decoded control bits from ID/EX
//   ALUControlE [2:0]   ALU operation select
//   RD1_E, RD2_E [31:0] register file read data (rs1, rs2)
//   Imm_Ext_E [31:0]    sign-extended immediate
//   RD_E [4:0]          destination register index
//   PCE, PCPlus4E       instruction PC and PC+4
//   ResultW [31:0]      writeback-stage result (forwarding source)
//   ForwardA_E, ForwardB_E [1:0]  forwarding selects from the hazard unit
//   PCSrcE              branch taken (combinational)
//   PCTargetE [31:0]    branch target (combinational)
//   RegWriteM, ResultSrcM, MemWriteM    registered control to memory stage
//   ALUResultM, WriteDataM, PCPlus4M    registered data to memory stage
//   RDM [4:0]           registered destination index

module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic        ALUSrcE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        ResultSrcM,
    output logic        MemWriteM,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M,
    output logic [4:0]  RDM
);

    // EX/MEM pipeline register
    logic        reg_write_reg;
    logic        result_src_reg;
    logic        mem_write_reg;
    logic [31:0] alu_result_reg;
    logic [31:0] write_data_reg;
    logic [31:0] pc_plus4_reg;
    logic [4:0]  rd_reg;

    // Forwarding: index 0 is operand A (rs1), index 1 is forwarded rs2
    logic [1:0][1:0]  fwd_sel;
    logic [1:0][31:0] fwd_raw;
    logic [1:0][31:0] fwd_val;

    assign fwd_sel[0] = ForwardA_E;
    assign fwd_sel[1] = ForwardB_E;
    assign fwd_raw[0] = RD1_E;
    assign fwd_raw[1] = RD2_E;

    // Select 11 falls through to the register file value so an unused
    // encoding can never inject an undriven value into the datapath.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_val[gi] = (fwd_sel[gi] == 2'b01) ? ResultW        :
                                 (fwd_sel[gi] == 2'b10) ? alu_result_reg :
                                                          fwd_raw[gi];
        end
    endgenerate

    logic [31:0] src_a;
    logic [31:0] write_data_e;
    logic [31:0] src_b;
    logic [31:0] alu_result_next;
    logic        zero_e;

    assign src_a        = fwd_val[0];
    assign write_data_e = fwd_val[1];
    // Stores need the forwarded rs2 even when B takes the immediate address offset
    assign src_b        = ALUSrcE ? Imm_Ext_E : write_data_e;

    always_comb begin
        alu_result_next = 32'd0;
        case (ALUControlE)
            3'b000: alu_result_next = src_a + src_b;
            3'b001: alu_result_next = src_a - src_b;
            3'b010: alu_result_next = src_a & src_b;
            3'b011: alu_result_next = src_a | src_b;
            3'b100: alu_result_next = src_a ^ src_b;
            3'b101: alu_result_next = ($signed(src_a) < $signed(src_b)) ? 32'd1 : 32'd0;
            3'b110: alu_result_next = src_a << src_b[4:0];
            3'b111: alu_result_next = src_a >> src_b[4:0];
            default: alu_result_next = 32'd0;
        endcase
    end

    assign zero_e    = (alu_result_next == 32'd0);
    assign PCSrcE    = BranchE & zero_e;
    assign PCTargetE = PCE + Imm_Ext_E;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_reg  <= 1'b0;
            result_src_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            alu_result_reg <= 32'd0;
            write_data_reg <= 32'd0;
            pc_plus4_reg   <= 32'd0;
            rd_reg         <= 5'd0;
        end else begin
            reg_write_reg  <= RegWriteE;
            result_src_reg <= ResultSrcE;
            mem_write_reg  <= MemWriteE;
            alu_result_reg <= alu_result_next;
            write_data_reg <= write_data_e;
            pc_plus4_reg   <= PCPlus4E;
            rd_reg         <= RD_E;
        end
    end

    assign RegWriteM  = reg_write_reg;
    assign ResultSrcM = result_src_reg;
    assign MemWriteM  = mem_write_reg;
    assign ALUResultM = alu_result_reg;
    assign WriteDataM = write_data_reg;
    assign PCPlus4M   = pc_plus4_reg;
    assign RDM        = rd_reg;

endmodule
